untilsat_ctrl_seq: RTL and testbench

- Sequential, parametrised successor to the single-output until-saturation control function.
- Runs CHANNELS independent saturating accumulators that step each cycle until each reaches a programmed limit.
- Raises done when every armed channel has saturated, or when a cycle budget expires.
- Sits between the benchmark stimulus driver and downstream result capture; y0 keeps the legacy single-bit "all saturated" meaning.

---
 rtl/untilsat_ctrl_seq_if.sv | 29 ++
 rtl/untilsat_ctrl_seq.sv | 118 +++++++++++
 tb/tb_untilsat_ctrl_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/untilsat_ctrl_seq_if.sv
// Handshake and result bundle for the until-saturation controller.
// The master drives the run request and its parameters; the slave (the
// controller) returns status, per-channel flags and accumulator values.
interface untilsat_ctrl_seq_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP_W   = 4
);
  logic                      start;
  logic [WIDTH-1:0]          limit;
  logic [STEP_W-1:0]         step;
  logic [CHANNELS-1:0]       arm;
  logic                      busy;
  logic                      done;
  logic                      timeout;
  logic [CHANNELS-1:0]       sat;
  logic [CHANNELS*WIDTH-1:0] count;
  logic                      y0;

  modport master (
    output start, limit, step, arm,
    input  busy, done, timeout, sat, count, y0
  );

  modport slave (
    input  start, limit, step, arm,
    output busy, done, timeout, sat, count, y0
  );
endinterface

// File: rtl/untilsat_ctrl_seq.sv
// Until-saturation controller: CHANNELS saturating accumulators step by a
// shared increment each RUN cycle until each reaches the captured limit.
// The run ends when every armed channel is saturated, or when the cycle
// budget expires; saturation takes priority when both happen together.
module untilsat_ctrl_seq #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP_W   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  untilsat_ctrl_seq_if.slave   bus
);

  localparam int CYC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state_q;
  logic [WIDTH-1:0]                limit_q;
  logic [STEP_W-1:0]               step_q;
  logic [CHANNELS-1:0]             arm_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  count_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  count_d;
  logic [CHANNELS-1:0]             sat_q;
  logic [CHANNELS-1:0]             sat_d;
  logic [CYC_W-1:0]                cycCnt_q;
  logic                            done_q;
  logic                            timeout_q;
  logic [WIDTH:0]                  sum;
  logic                            allSat;

  // Next accumulator values for one RUN step; the extra sum bit means a
  // large step near the top of the range clamps to limit instead of wrapping.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    sum     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (arm_q[c] && !sat_q[c]) begin
        sum = {1'b0, count_q[c]} + (WIDTH+1)'(step_q);
        if (sum >= {1'b0, limit_q}) begin
          count_d[c] = limit_q;
          sat_d[c]   = 1'b1;
        end else begin
          count_d[c] = sum[WIDTH-1:0];
        end
      end
    end
    allSat = &(sat_d | ~arm_q);
  end

  // Control FSM with registered outputs: capture on start, step in RUN,
  // one-cycle done pulse in DONE, results held until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      limit_q   <= '0;
      step_q    <= '0;
      arm_q     <= '0;
      count_q   <= '0;
      sat_q     <= '0;
      cycCnt_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            limit_q   <= bus.limit;
            step_q    <= bus.step;
            arm_q     <= bus.arm;
            count_q   <= '0;
            sat_q     <= bus.arm & {CHANNELS{bus.limit == '0}};
            timeout_q <= 1'b0;
            cycCnt_q  <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          count_q  <= count_d;
          sat_q    <= sat_d;
          cycCnt_q <= cycCnt_q + CYC_W'(1);
          if (allSat) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cycCnt_q == CYC_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.sat     = sat_q;
  assign bus.count   = count_q;
  assign bus.y0      = &(sat_q | ~arm_q);

endmodule

// File: tb/tb_untilsat_ctrl_seq.sv
// Directed bench for untilsat_ctrl_seq: three instances cover the default
// budget, a short budget of 8 cycles and a budget of 4 cycles.
module tb_untilsat_ctrl_seq;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  untilsat_ctrl_seq_if #(.WIDTH(8), .CHANNELS(4), .STEP_W(4)) busA ();
  untilsat_ctrl_seq_if #(.WIDTH(8), .CHANNELS(4), .STEP_W(4)) busB ();
  untilsat_ctrl_seq_if #(.WIDTH(8), .CHANNELS(4), .STEP_W(4)) busC ();

  untilsat_ctrl_seq #(.WIDTH(8), .CHANNELS(4), .STEP_W(4), .TIMEOUT(255)) dutA (
    .clk(clk), .rst(rst), .bus(busA.slave)
  );
  untilsat_ctrl_seq #(.WIDTH(8), .CHANNELS(4), .STEP_W(4), .TIMEOUT(8)) dutB (
    .clk(clk), .rst(rst), .bus(busB.slave)
  );
  untilsat_ctrl_seq #(.WIDTH(8), .CHANNELS(4), .STEP_W(4), .TIMEOUT(4)) dutC (
    .clk(clk), .rst(rst), .bus(busC.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start request on one instance for exactly one clock edge
  task automatic pulseStart(input int which, input logic [7:0] l,
                            input logic [3:0] s, input logic [3:0] a);
    case (which)
      0: begin busA.start = 1'b1; busA.limit = l; busA.step = s; busA.arm = a; end
      1: begin busB.start = 1'b1; busB.limit = l; busB.step = s; busB.arm = a; end
      default: begin busC.start = 1'b1; busC.limit = l; busC.step = s; busC.arm = a; end
    endcase
    tick();
    busA.start = 1'b0;
    busB.start = 1'b0;
    busC.start = 1'b0;
  endtask

  // Reset state, then an asynchronous reset in the 2nd RUN cycle
  task automatic test_reset();
    rst = 1'b1;
    #3;
    testsRun++;
    if ({busA.busy, busA.done, busA.timeout, busA.sat, busA.y0} !== 8'b0000_0001) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got %b expected 00000001",
               {busA.busy, busA.done, busA.timeout, busA.sat, busA.y0});
    end
    testsRun++;
    if (busA.count !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count: got %h expected 00000000", busA.count);
    end
    tick();
    rst = 1'b0;
    tick();
    pulseStart(0, 8'd10, 4'd3, 4'b1111);
    tick();
    testsRun++;
    if (busA.count !== 32'h03030303 || busA.busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrun_progress: got count %h busy %b expected 03030303 1",
               busA.count, busA.busy);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if (busA.count !== 32'h0 || busA.sat !== 4'b0 || busA.busy !== 1'b0 || busA.y0 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset: got count %h sat %b busy %b y0 %b expected 0 0 0 1",
               busA.count, busA.sat, busA.busy, busA.y0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) rst = 1'b0;
      testsRun++;
      if (busA.done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL midrun_no_done: got %b expected 0 (cycle %0d)", busA.done, i);
      end
    end
  endtask

  // limit=10 step=3 arm=0101: 3,6,9,10 then done
  task automatic test_basic();
    logic [7:0] expCnt [4];
    expCnt[0] = 8'd3; expCnt[1] = 8'd6; expCnt[2] = 8'd9; expCnt[3] = 8'd10;
    pulseStart(0, 8'd10, 4'd3, 4'b0101);
    for (int k = 0; k < 4; k++) begin
      tick();
      testsRun++;
      if (busA.count[7:0] !== expCnt[k] || busA.count[23:16] !== expCnt[k]) begin
        testsFailed++;
        $display("[TB] FAIL basic_count%0d: got ch0 %0d ch2 %0d expected %0d",
                 k, busA.count[7:0], busA.count[23:16], expCnt[k]);
      end
    end
    testsRun++;
    if ({busA.sat, busA.done, busA.timeout, busA.y0, busA.busy} !== 8'b0101_1010) begin
      testsFailed++;
      $display("[TB] FAIL basic_finish: got sat/done/to/y0/busy %b expected 01011010",
               {busA.sat, busA.done, busA.timeout, busA.y0, busA.busy});
    end
    testsRun++;
    if (busA.count[15:8] !== 8'd0 || busA.count[31:24] !== 8'd0) begin
      testsFailed++;
      $display("[TB] FAIL basic_unarmed: got ch1 %0d ch3 %0d expected 0 0",
               busA.count[15:8], busA.count[31:24]);
    end
    tick();
    testsRun++;
    if (busA.done !== 1'b0 || busA.count[7:0] !== 8'd10) begin
      testsFailed++;
      $display("[TB] FAIL basic_pulse_hold: got done %b ch0 %0d expected 0 10",
               busA.done, busA.count[7:0]);
    end
  endtask

  // limit=255 step=15: 240 after 16 steps, 255 with no wrap after 17
  task automatic test_overflow();
    pulseStart(0, 8'd255, 4'd15, 4'b0001);
    for (int k = 0; k < 16; k++) tick();
    testsRun++;
    if (busA.count[7:0] !== 8'd240 || busA.sat[0] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL overflow_16: got %0d sat %b expected 240 0",
               busA.count[7:0], busA.sat[0]);
    end
    tick();
    testsRun++;
    if (busA.count[7:0] !== 8'd255 || busA.sat[0] !== 1'b1 || busA.done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL overflow_17: got %0d sat %b done %b expected 255 1 1",
               busA.count[7:0], busA.sat[0], busA.done);
    end
    tick();
  endtask

  // step=0, TIMEOUT=8: exactly 8 busy cycles, then sticky timeout
  task automatic test_timeout();
    int n;
    pulseStart(1, 8'd5, 4'd0, 4'b0001);
    n = 0;
    while (busB.busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    testsRun++;
    if (n !== 8) begin
      testsFailed++;
      $display("[TB] FAIL timeout_len: got %0d busy cycles expected 8", n);
    end
    testsRun++;
    if ({busB.done, busB.timeout, busB.y0} !== 3'b110 || busB.count !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_finish: got done/to/y0 %b count %h expected 110 0",
               {busB.done, busB.timeout, busB.y0}, busB.count);
    end
    tick();
    testsRun++;
    if (busB.timeout !== 1'b1 || busB.done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_sticky: got to %b done %b expected 1 0",
               busB.timeout, busB.done);
    end
    pulseStart(1, 8'd0, 4'd2, 4'b0001);
    testsRun++;
    if (busB.timeout !== 1'b0 || busB.busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_clear: got to %b busy %b expected 0 1",
               busB.timeout, busB.busy);
    end
    tick();
    testsRun++;
    if ({busB.done, busB.timeout, busB.y0, busB.sat} !== 7'b101_0001) begin
      testsFailed++;
      $display("[TB] FAIL limit0_done: got done/to/y0/sat %b expected 1010001",
               {busB.done, busB.timeout, busB.y0, busB.sat});
    end
    tick();
  endtask

  // Empty arm mask finishes after one RUN cycle; start during RUN is ignored
  task automatic test_edge_masks();
    pulseStart(0, 8'd10, 4'd3, 4'b0000);
    testsRun++;
    if (busA.busy !== 1'b1 || busA.done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL empty_run: got busy %b done %b expected 1 0", busA.busy, busA.done);
    end
    tick();
    testsRun++;
    if (busA.done !== 1'b1 || busA.y0 !== 1'b1 || busA.count !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL empty_done: got done %b y0 %b count %h expected 1 1 0",
               busA.done, busA.y0, busA.count);
    end
    tick();
    pulseStart(0, 8'd10, 4'd3, 4'b0001);
    pulseStart(0, 8'd50, 4'd1, 4'b1111);
    testsRun++;
    if (busA.count !== 32'h00000003) begin
      testsFailed++;
      $display("[TB] FAIL ignore_start: got count %h expected 00000003", busA.count);
    end
    tick();
    tick();
    tick();
    testsRun++;
    if (busA.done !== 1'b1 || busA.count !== 32'h0000000A || busA.sat !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL ignore_len: got done %b count %h sat %b expected 1 0000000a 0001",
               busA.done, busA.count, busA.sat);
    end
    tick();
  endtask

  // TIMEOUT=4, limit=12 step=3: saturation and budget coincide, saturation wins
  task automatic test_simultaneous();
    pulseStart(2, 8'd12, 4'd3, 4'b0011);
    for (int k = 0; k < 3; k++) tick();
    testsRun++;
    if (busC.done !== 1'b0 || busC.count[7:0] !== 8'd9) begin
      testsFailed++;
      $display("[TB] FAIL simul_pre: got done %b ch0 %0d expected 0 9", busC.done, busC.count[7:0]);
    end
    tick();
    testsRun++;
    if ({busC.done, busC.timeout, busC.y0} !== 3'b101 || busC.count !== 32'h00000C0C) begin
      testsFailed++;
      $display("[TB] FAIL simul_exit: got done/to/y0 %b count %h expected 101 00000c0c",
               {busC.done, busC.timeout, busC.y0}, busC.count);
    end
    tick();
  endtask

  // Run every scenario in order and report
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    busA.start = 1'b0; busA.limit = '0; busA.step = '0; busA.arm = '0;
    busB.start = 1'b0; busB.limit = '0; busB.step = '0; busB.arm = '0;
    busC.start = 1'b0; busC.limit = '0; busC.step = '0; busC.arm = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_edge_masks();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
